instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the synchronous-read instruction memory. Owns the program counter and drives the memory word address.
- Accounts for the memory's fixed one-cycle read latency and buffers returned words in a small FIFO.
- Presents {instruction, PC} to decode with a valid/ready handshake. Supports stall from decode and redirect from branch/jump resolution.

---
 rtl/instruction_fetch_unit.sv | 92 +++++++++
 tb/tb_instruction_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the synchronous-read instruction memory,
// and buffers returned words in a small FIFO presented to decode via valid/ready.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop_c;
  logic          issue_c;
  logic          wr_c;
  logic [CW:0]   occ_c;
  logic          unused_c;

  assign mem_addr   = {pc[31:2], 2'b00};
  assign inst_valid = (count != '0);
  assign inst       = fifo_inst[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign unused_c   = ^redirect_pc[1:0];

  // Credit check: entries held plus the word in flight, after this cycle's pop
  always_comb begin
    pop_c   = inst_valid & inst_ready;
    occ_c   = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop_c);
    issue_c = !reset && !redirect_valid && (occ_c < (CW+1)'(DEPTH));
    wr_c    = inflight && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: drop buffered words and the returning word, restart at the target
      pc       <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (wr_c) begin
        fifo_inst[wr_ptr] <= mem_inst;
        fifo_pc[wr_ptr]   <= inflight_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(wr_c) - CW'(pop_c);
    end
  end

  // The credit rule must never let a write land in a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(wr_c && !pop_c && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written redirect
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic [31:0] mem_addr, mem_inst = '0, inst, inst_pc;
  logic        inst_valid;
  logic [31:0] w_mem_addr, w_mem_inst = '0, w_inst, w_inst_pc;
  logic        w_inst_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_inst(mem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset(reset), .mem_addr(w_mem_addr), .mem_inst(w_mem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst(w_inst), .inst_pc(w_inst_pc)
  );

  // Memory image: word i holds the value i
  function automatic logic [31:0] memw(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // Synchronous-read instruction memories, one-cycle latency
  always @(posedge clk) begin
    mem_inst   <= memw(mem_addr);
    w_mem_inst <= memw(w_mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rpc;
    logic        chk_en, exp_v, chk_d;
    logic [31:0] exp_inst, exp_pc, exp_ma;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic chk_en, input logic ev,
                              input logic cd, input logic [31:0] ei, input logic [31:0] ep,
                              input logic [31:0] ema);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.chk_en = chk_en; v.exp_v = ev; v.chk_d = cd;
    v.exp_inst = ei; v.exp_pc = ep; v.exp_ma = ema;
    return v;
  endfunction

  // Drive one cycle's inputs at the falling edge, then check the current outputs
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; inst_ready = v.rdy; redirect_valid = v.rv; redirect_pc = v.rpc;
    #1;
    if (v.chk_en) begin
      chk({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, v.exp_v});
      chk({tag, " mem_addr"}, mem_addr, v.exp_ma);
      if (v.chk_d) begin
        chk({tag, " inst"}, inst, v.exp_inst);
        chk({tag, " inst_pc"}, inst_pc, v.exp_pc);
      end
    end
  endtask

  // Reference model: fetched words as a queue, plus the single address awaiting data
  typedef struct packed { logic [31:0] i; logic [31:0] p; } ent_t;
  ent_t        mq[$];
  bit          m_pipe_v;
  logic [31:0] m_pipe_pc;
  logic [31:0] m_pc;

  task automatic model_step(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit pop, iss;
    int occ;
    if (rst) begin
      mq.delete(); m_pipe_v = 0; m_pc = 32'h0;
    end else if (rv) begin
      mq.delete(); m_pipe_v = 0; m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      pop = (mq.size() > 0) && rdy;
      occ = mq.size() + int'(m_pipe_v) - int'(pop);
      iss = occ < int'(DEPTH);
      if (pop) void'(mq.pop_front());
      if (m_pipe_v) mq.push_back({memw(m_pipe_pc), m_pipe_pc});
      m_pipe_v = iss;
      if (iss) begin
        m_pipe_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
  endtask

  vec_t        tbl[24];
  logic [31:0] wrap_pc[3];
  logic [31:0] wrap_inst[3];

  initial begin
    // Run, reset mid-stream, stall from first valid, release, fill, reset while full, rerun
    tbl[0]  = mk(1,1,0,0, 0,0,0, 0,0,0);
    tbl[1]  = mk(0,1,0,0, 1,0,1, 0,0,32'h0);
    tbl[2]  = mk(0,1,0,0, 1,0,0, 0,0,32'h4);
    tbl[3]  = mk(0,1,0,0, 1,1,1, 0,32'h0,32'h8);
    tbl[4]  = mk(0,1,0,0, 1,1,1, 1,32'h4,32'hC);
    tbl[5]  = mk(0,1,0,0, 1,1,1, 2,32'h8,32'h10);
    tbl[6]  = mk(1,1,0,0, 1,1,1, 3,32'hC,32'h14);
    tbl[7]  = mk(0,0,0,0, 1,0,1, 0,0,32'h0);
    tbl[8]  = mk(0,0,0,0, 1,0,0, 0,0,32'h4);
    for (int k = 9; k <= 13; k++) tbl[k] = mk(0,0,0,0, 1,1,1, 0,32'h0,32'h8);
    tbl[14] = mk(0,1,0,0, 1,1,1, 0,32'h0,32'h8);
    tbl[15] = mk(0,1,0,0, 1,1,1, 1,32'h4,32'hC);
    tbl[16] = mk(0,0,0,0, 1,1,1, 2,32'h8,32'h10);
    tbl[17] = mk(0,0,0,0, 1,1,1, 2,32'h8,32'h10);
    tbl[18] = mk(1,0,0,0, 1,1,1, 2,32'h8,32'h10);
    tbl[19] = mk(0,1,0,0, 1,0,1, 0,0,32'h0);
    tbl[20] = mk(0,1,0,0, 1,0,0, 0,0,32'h4);
    tbl[21] = mk(0,1,0,0, 1,1,1, 0,32'h0,32'h8);
    tbl[22] = mk(0,1,0,0, 1,1,1, 1,32'h4,32'hC);
    tbl[23] = mk(0,1,0,0, 1,1,1, 2,32'h8,32'h10);
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0000_0000;
    wrap_inst[0] = 32'h3FFF_FFFE; wrap_inst[1] = 32'h3FFF_FFFF; wrap_inst[2] = 32'h0;

    for (int r = 0; r < 24; r++) begin
      apply(tbl[r], $sformatf("row%0d", r));
      if (r == 1) chk("wrap mem_addr", w_mem_addr, 32'hFFFF_FFF8);
      if (r >= 3 && r <= 5) begin
        chk($sformatf("wrap%0d valid", r - 3), {31'b0, w_inst_valid}, 32'h1);
        chk($sformatf("wrap%0d inst_pc", r - 3), w_inst_pc, wrap_pc[r - 3]);
        chk($sformatf("wrap%0d inst", r - 3), w_inst, wrap_inst[r - 3]);
      end
    end

    // Redirect with one buffered entry and one in flight, then a redirect coinciding
    // with a pop followed immediately by a second redirect
    apply(mk(1,0,0,0,           0,0,0, 0,0,0),                  "rd_a");
    apply(mk(0,0,0,0,           1,0,0, 0,0,32'h0),              "rd_b");
    apply(mk(0,0,0,0,           1,0,0, 0,0,32'h4),              "rd_c");
    apply(mk(0,0,1,32'h103,     1,1,1, 0,32'h0,32'h8),          "rd_d");
    apply(mk(0,1,0,0,           1,0,0, 0,0,32'h100),            "rd_e");
    apply(mk(0,1,0,0,           1,0,0, 0,0,32'h104),            "rd_f");
    apply(mk(0,1,0,0,           1,1,1, 32'h40,32'h100,32'h108), "rd_g");
    apply(mk(0,1,1,32'h100,     1,1,1, 32'h41,32'h104,32'h10C), "rd_h");
    apply(mk(0,1,1,32'h200,     1,0,0, 0,0,32'h100),            "rd_i");
    apply(mk(0,1,0,0,           1,0,0, 0,0,32'h200),            "rd_j");
    apply(mk(0,1,0,0,           1,0,0, 0,0,32'h204),            "rd_k");
    apply(mk(0,1,0,0,           1,1,1, 32'h80,32'h200,32'h208), "rd_l");
    apply(mk(0,1,0,0,           1,1,1, 32'h81,32'h204,32'h20C), "rd_m");

    // Randomized traffic against the reference model, starting from reset
    for (int c = 0; c < 3000; c++) begin
      bit          rst, rdy, rv;
      logic [31:0] rpc;
      rst = (c == 0) || ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      @(negedge clk);
      reset = rst; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      #1;
      if (c > 0) begin
        chk($sformatf("rnd%0d inst_valid", c), {31'b0, inst_valid}, {31'b0, mq.size() > 0});
        chk($sformatf("rnd%0d mem_addr", c), mem_addr, m_pc);
        if (mq.size() > 0) begin
          chk($sformatf("rnd%0d inst", c), inst, mq[0].i);
          chk($sformatf("rnd%0d inst_pc", c), inst_pc, mq[0].p);
        end
      end
      model_step(rst, rdy, rv, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
